// File: rtl/factor_sequencer_if.sv
// Request/acknowledge bus between the factor sequencer and the external divider unit.
interface factor_sequencer_if;
    logic       div_req;
    logic [7:0] div_dividend;
    logic [7:0] div_divisor;
    logic       div_ack;
    logic [7:0] div_quotient;
    logic [7:0] div_remainder;

    modport master (
        output div_req,
        output div_dividend,
        output div_divisor,
        input  div_ack,
        input  div_quotient,
        input  div_remainder
    );

    modport slave (
        input  div_req,
        input  div_dividend,
        input  div_divisor,
        output div_ack,
        output div_quotient,
        output div_remainder
    );
endinterface

// File: rtl/factor_sequencer.sv
// Trial-division factorizer controller: latches an 8-bit operand, steps a trial
// divisor through an external divider, and emits each prime factor in ascending
// order, holding each one for HOLD_CYCLES so the display path can show it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_CHECK | decide: finished (n==1), n itself prime (d*d>n), or divide
// S_REQ   | divide request outstanding, waiting for div_ack
// S_EMIT  | one-cycle factor strobe
// S_HOLD  | display hold, HOLD_CYCLES cycles
// S_DONE  | result flags valid, waiting for a new start
module factor_sequencer #(
    parameter int unsigned HOLD_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          number,
    factor_sequencer_if.master  div,
    output logic [7:0]          factor,
    output logic                factor_strobe,
    output logic [2:0]          factor_count,
    output logic                busy,
    output logic                done,
    output logic                is_prime,
    output logic                invalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_EMIT,
        S_HOLD,
        S_DONE
    } state_t;

    // The hold counter runs HOLD_LOAD..0, giving exactly HOLD_CYCLES cycles in S_HOLD.
    localparam logic [23:0] HOLD_LOAD = 24'(HOLD_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  n_q, n_nx;
    logic [7:0]  d_q, d_nx;
    logic [7:0]  factor_q, factor_nx;
    logic [2:0]  count_q, count_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;
    logic        prime_q, prime_nx;
    logic        invalid_q, invalid_nx;
    logic [23:0] hold_q, hold_nx;
    logic [15:0] d_sq;

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n_q       <= 8'd0;
            d_q       <= 8'd0;
            factor_q  <= 8'd0;
            count_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prime_q   <= 1'b0;
            invalid_q <= 1'b0;
            hold_q    <= 24'd0;
        end else begin
            state     <= state_nx;
            n_q       <= n_nx;
            d_q       <= d_nx;
            factor_q  <= factor_nx;
            count_q   <= count_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            prime_q   <= prime_nx;
            invalid_q <= invalid_nx;
            hold_q    <= hold_nx;
        end
    end

    // Next-state and datapath update; factor and count change on entry to S_EMIT
    // so both are already valid during the strobe cycle.
    always_comb begin
        state_nx   = state;
        n_nx       = n_q;
        d_nx       = d_q;
        factor_nx  = factor_q;
        count_nx   = count_q;
        busy_nx    = busy_q;
        done_nx    = done_q;
        prime_nx   = prime_q;
        invalid_nx = invalid_q;
        hold_nx    = hold_q;
        d_sq       = 16'(d_q) * 16'(d_q);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_nx     = number;
                    d_nx     = 8'd2;
                    count_nx = 3'd0;
                    prime_nx = 1'b0;
                    if (number < 8'd2) begin
                        state_nx   = S_DONE;
                        done_nx    = 1'b1;
                        invalid_nx = 1'b1;
                        busy_nx    = 1'b0;
                    end else begin
                        state_nx   = S_CHECK;
                        done_nx    = 1'b0;
                        invalid_nx = 1'b0;
                        busy_nx    = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (n_q == 8'd1) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    prime_nx = (count_q == 3'd1);
                end else if (d_sq > {8'd0, n_q}) begin
                    // No divisor up to sqrt(n) remains, so the residual is prime.
                    factor_nx = n_q;
                    n_nx      = 8'd1;
                    count_nx  = count_q + 3'd1;
                    state_nx  = S_EMIT;
                end else begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (div.div_ack) begin
                    if (div.div_remainder == 8'd0) begin
                        factor_nx = d_q;
                        n_nx      = div.div_quotient;
                        count_nx  = count_q + 3'd1;
                        state_nx  = S_EMIT;
                    end else begin
                        d_nx     = d_q + 8'd1;
                        state_nx = S_CHECK;
                    end
                end
            end
            S_EMIT: begin
                hold_nx  = HOLD_LOAD;
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == 24'd0) begin
                    state_nx = S_CHECK;
                end else begin
                    hold_nx = hold_q - 24'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign div.div_req      = (state == S_REQ);
    assign div.div_dividend = n_q;
    assign div.div_divisor  = d_q;
    assign factor_strobe    = (state == S_EMIT);
    assign factor           = factor_q;
    assign factor_count     = count_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign is_prime         = prime_q;
    assign invalid          = invalid_q;

endmodule

// File: tb/tb_factor_sequencer.sv
// Self-checking bench for factor_sequencer: a behavioural divider on the bus,
// a trial-division reference model producing the expected factor list, and a
// per-cycle compare process on the strobe, hold timing and request protocol.
module tb_factor_sequencer;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] number = 8'd0;
    logic [7:0] factor;
    logic       factor_strobe;
    logic [2:0] factor_count;
    logic       busy, done, is_prime, invalid;
    logic       rst_q = 1'b1;

    factor_sequencer_if bus();

    factor_sequencer #(.HOLD_CYCLES(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .number       (number),
        .div          (bus.master),
        .factor       (factor),
        .factor_strobe(factor_strobe),
        .factor_count (factor_count),
        .busy         (busy),
        .done         (done),
        .is_prime     (is_prime),
        .invalid      (invalid)
    );

    always #5 clk = ~clk;

    // Reset as seen by the DUT on the last rising edge.
    always @(posedge clk) rst_q <= reset;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_total   = 0;
    int req_rises   = 0;
    int strobe_total = 0;
    bit rnd_delay   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain trial division, factors in ascending order.
    task automatic load_model(input int n);
        int r;
        int d;
        exp_q.delete();
        r = n;
        d = 2;
        if (n >= 2) begin
            while (d * d <= r) begin
                if (r % d == 0) begin
                    exp_q.push_back(d);
                    r = r / d;
                end else begin
                    d++;
                end
            end
            if (r > 1) exp_q.push_back(r);
        end
        exp_total = exp_q.size();
    endtask

    // Behavioural divider: acks after a fixed 2-cycle or random 0..5-cycle delay,
    // and checks that the request operands stay put until the ack.
    bit       pending = 1'b0;
    int       wait_left = 0;
    int       rec_n = 0;
    int       rec_d = 0;
    always @(negedge clk) begin
        bus.div_ack       = 1'b0;
        bus.div_quotient  = 8'd0;
        bus.div_remainder = 8'd0;
        if (rst_q) begin
            pending = 1'b0;
        end else if (!bus.div_req) begin
            if (pending) check("req_held_until_ack", 0, 1);
            pending = 1'b0;
        end else if (!pending) begin
            pending   = 1'b1;
            req_rises++;
            rec_n     = int'(bus.div_dividend);
            rec_d     = int'(bus.div_divisor);
            wait_left = rnd_delay ? int'($urandom_range(0, 5)) : 2;
            check("req_divisor_le_15", int'(rec_d <= 15 && rec_d >= 2), 1);
        end else begin
            check("req_dividend_stable", int'(bus.div_dividend), rec_n);
            check("req_divisor_stable", int'(bus.div_divisor), rec_d);
        end
        if (pending) begin
            if (wait_left == 0) begin
                bus.div_ack       = 1'b1;
                bus.div_quotient  = 8'(rec_n / rec_d);
                bus.div_remainder = 8'(rec_n % rec_d);
                pending           = 1'b0;
            end else begin
                wait_left--;
            end
        end
    end

    // Per-cycle compare against the model: strobed factors, count, spacing and hold latency.
    int       cycle = 0;
    int       last_strobe = 0;
    bit       have_strobe = 1'b0;
    logic     prev_req = 1'b0;
    logic [7:0] prev_factor = 8'd0;
    always @(negedge clk) begin
        int f;
        cycle++;
        if (rst_q) begin
            have_strobe = 1'b0;
        end else begin
            if (factor_strobe) begin
                strobe_total++;
                if (exp_q.size() == 0) begin
                    check("strobe_expected", 0, 1);
                end else begin
                    f = exp_q.pop_front();
                    check("strobe_factor", int'(factor), f);
                    check("strobe_count", int'(factor_count), exp_total - exp_q.size());
                end
                if (have_strobe) check("strobe_spacing", int'(cycle - last_strobe >= H + 1), 1);
                have_strobe = 1'b1;
                last_strobe = cycle;
            end
            if (bus.div_req && !prev_req && have_strobe)
                check("req_after_hold", int'(cycle - last_strobe >= H + 2), 1);
            if (busy && !factor_strobe)
                check("factor_stable", int'(factor), int'(prev_factor));
        end
        prev_req    = bus.div_req;
        prev_factor = factor;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_div_req"}, int'(bus.div_req), 0);
        check({tag, "_dividend"}, int'(bus.div_dividend), 0);
        check({tag, "_divisor"}, int'(bus.div_divisor), 0);
        check({tag, "_factor"}, int'(factor), 0);
        check({tag, "_strobe"}, int'(factor_strobe), 0);
        check({tag, "_count"}, int'(factor_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_is_prime"}, int'(is_prime), 0);
        check({tag, "_invalid"}, int'(invalid), 0);
    endtask

    // One factorization: literal expectations pin the model, model drives the checks.
    task automatic run(input int n, input int cnt_lit, input int last_lit,
                       input int mid, input int reqs_lit);
        int req0, str0, cyc;
        load_model(n);
        check("model_count", exp_total, cnt_lit);
        if (exp_total > 0) check("model_last", exp_q[$], last_lit);
        req0 = req_rises;
        str0 = strobe_total;
        @(negedge clk);
        number = 8'(n);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        if (n >= 2) begin
            check("busy_after_start", int'(busy), 1);
            check("done_cleared", int'(done), 0);
        end
        while (!done && cyc < 3000) begin
            if (cyc == mid) begin
                start  = 1'b1;
                number = 8'd12;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("done_reached", int'(done), 1);
        check("done_busy_low", int'(busy), 0);
        check("done_count", int'(factor_count), cnt_lit);
        check("done_invalid", int'(invalid), int'(n < 2));
        check("done_is_prime", int'(is_prime), int'(exp_total == 1));
        check("done_strobes", strobe_total - str0, cnt_lit);
        check("done_model_drained", exp_q.size(), 0);
        check("done_factor", int'(factor), last_lit);
        check("done_req_count", req_rises - req0, reqs_lit);
        if (n < 2) check("invalid_done_latency", int'(cyc <= 2), 1);
    endtask

    initial begin
        int k;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        run(12, 3, 3, 0, 2);
        run(13, 1, 13, 0, 2);
        run(255, 3, 17, 0, 5);
        run(0, 0, 17, 0, 0);
        run(1, 0, 17, 0, 0);
        rnd_delay = 1'b1;
        run(128, 7, 2, 0, 6);
        rnd_delay = 1'b0;

        // Abort N=12 during the hold after its first factor.
        load_model(12);
        @(negedge clk);
        number = 8'd12;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!factor_strobe && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_first_strobe_seen", int'(factor_strobe), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        exp_q.delete();

        run(7, 1, 7, 3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/factor_sequencer.md
Name: factor_sequencer

Overview:
- Controller for the trial-division factorizer datapath.
- Latches an 8-bit operand on `start`, then drives an external divider unit through a req/ack handshake, stepping the trial divisor.
- Emits each prime factor in ascending order, holding each on `factor` for a display period so the 7-segment path can show it.
- Sits between the input switches and the display/seconds-tick logic in the top level.

Parameters:
- HOLD_CYCLES, 10_000_000: cycles each emitted factor is held before the search resumes (one second at 10 MHz). Legal range 1 to 2^24-1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin factorization of `number`; sampled only in IDLE or DONE
- number  input  8  operand N
- div_req  output  1  divide request to divider unit
- div_dividend  output  8  current residual n
- div_divisor  output  8  current trial divisor d
- div_ack  input  1  one-cycle pulse; result valid in the same cycle
- div_quotient  input  8  n / d
- div_remainder  input  8  n % d
- factor  output  8  most recently emitted factor
- factor_strobe  output  1  one-cycle pulse when `factor` updates
- factor_count  output  3  number of factors emitted so far (max 7, e.g. 128 = 2^7)
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  high in DONE; cleared by next accepted start
- is_prime  output  1  valid while done: exactly one factor emitted
- invalid  output  1  valid while done: N was 0 or 1

Behaviour:
- Reset clears all outputs and internal registers to 0; state goes to IDLE.
- Reset mid-operation aborts immediately; `div_req` is low the cycle after reset is sampled. Any outstanding `div_ack` after reset is ignored.
- States: IDLE, CHECK, REQ, EMIT, HOLD, DONE.
- IDLE/DONE + start:
  - Latch n = number, d = 2.
  - Clear factor_count, done, is_prime, invalid; set busy.
  - Go to CHECK.
  - If number < 2, go directly to DONE with invalid = 1 and factor_count = 0.
- CHECK (1 cycle):
  - If n == 1, go to DONE.
  - Else if d*d > n (16-bit compare), set factor = n, n = 1, go to EMIT.
  - Else go to REQ.
- REQ:
  - `div_req` is high with `div_dividend` = n and `div_divisor` = d, all stable until `div_ack`.
  - On the ack cycle, capture quotient and remainder.
  - Remainder == 0: factor = d, n = quotient, go to EMIT (d unchanged).
  - Remainder != 0: d = d + 1, go to CHECK.
  - `div_req` is low the cycle after the ack.
  - `div_ack` outside REQ is ignored.
- EMIT (1 cycle): `factor_strobe` = 1, factor_count increments, go to HOLD.
- HOLD: stays exactly HOLD_CYCLES cycles (24-bit counter), then goes to CHECK.
  - The next `div_req` rises no earlier than strobe cycle + HOLD_CYCLES + 2.
- DONE:
  - done = 1, busy = 0, is_prime = (factor_count == 1).
  - `factor` retains the last value.
  - A start in DONE restarts the sequence; start in any other state is ignored.
- d never exceeds 16 while CHECK passes to REQ, since d*d > 255 terminates the search. No d overflow is possible.
- `factor` changes only in the EMIT cycle or on reset.

Test Plan:
- HOLD_CYCLES = 4, ideal divider acking 2 cycles after req, N = 12:
  - strobes with factor = 2, 2, 3; factor_count = 3; done = 1, is_prime = 0, invalid = 0.
- N = 13:
  - divides by d = 2 and 3 only, then single strobe factor = 13; is_prime = 1, factor_count = 1.
- N = 255:
  - factors 3, 5, 17 in order; no req with divisor > 15.
- N = 0 then N = 1:
  - done within 2 cycles of start; invalid = 1, factor_count = 0, no strobe, no div_req.
- N = 128 with divider delay 0–5 random cycles:
  - seven strobes of 2, factor_count = 7.
  - Strobe spacing ≥ HOLD_CYCLES + 1; req operands stable until ack.
- Reset asserted during HOLD of N = 12, then start with N = 7:
  - all outputs 0 the cycle after reset; new run emits only 7, is_prime = 1.
  - A start pulsed mid-run is ignored.
